// File: rtl/dm_copy_pkg.sv
// Shared constants and state encoding for the data-memory block-copy engine.
package dm_copy_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 11;
  localparam int MAX_LEN = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } dmc_state_t;

endpackage

// File: rtl/dm_copy_engine.sv
// Block-copy initiator for the single-port data memory (two cycles per byte).
// Optional fill mode (constant-pattern writes, one cycle per byte) under DM_COPY_FILL_EN.
module dm_copy_engine
  import dm_copy_pkg::*;
#(
  parameter int ADDR_W = dm_copy_pkg::ADDR_W,
  parameter int DATA_W = dm_copy_pkg::DATA_W,
  parameter int LEN_W  = dm_copy_pkg::LEN_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              DM_EN,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [DATA_W-1:0] DM_IN,
  input  logic [DATA_W-1:0] DM_OUT
`ifdef DM_COPY_FILL_EN
  ,
  input  logic              FILL,
  input  logic [DATA_W-1:0] FILL_DATA
`endif
);

  dmc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dm_en_q, dm_en_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_in_q, dm_in_d;

  logic              fill_in;
  logic [DATA_W-1:0] fill_data_in;
  logic [LEN_W-1:0]  len_clamped;

`ifdef DM_COPY_FILL_EN
  assign fill_in      = FILL;
  assign fill_data_in = FILL_DATA;
`else
  assign fill_in      = 1'b0;
  assign fill_data_in = '0;
`endif

  assign len_clamped = (LEN > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    fill_data_d = fill_data_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          src_d       = SRC_ADDR;
          dst_d       = DST_ADDR;
          cnt_d       = len_clamped;
          fill_d      = fill_in;
          fill_data_d = fill_data_in;
          if (len_clamped == '0) state_d = FIN;
          else if (fill_in)      state_d = WR;
          else                   state_d = RD;
        end
      end
      RD: begin
        buf_d   = DM_OUT;
        state_d = WR;
      end
      WR: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q > LEN_W'(1)) state_d = fill_q ? WR : RD;
        else                   state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    busy_d    = (state_d == RD) || (state_d == WR);
    done_d    = (state_d == FIN);
    dm_en_d   = (state_d == WR);
    dm_addr_d = '0;
    dm_in_d   = '0;
    if (state_d == RD) dm_addr_d = src_d;
    if (state_d == WR) begin
      dm_addr_d = dst_d;
      dm_in_d   = fill_d ? fill_data_d : buf_d;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      // NOTE: the byte buffer is a single register, not a RAM, so clearing it on reset is cheap.
      buf_q       <= '0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dm_en_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_in_q     <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dm_en_q     <= dm_en_d;
      dm_addr_q   <= dm_addr_d;
      dm_in_q     <= dm_in_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign DM_EN   = dm_en_q;
  assign DM_ADDR = dm_addr_q;
  assign DM_IN   = dm_in_q;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Scoreboard bench for dm_copy_engine: a reference memory model predicts every read, write and DONE.
// Fill-mode scenario is compiled in with DM_COPY_FILL_EN.
module tb_dm_copy_engine;

  typedef struct {
    int         n;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int         n;
    logic [9:0] addr;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst_n_s;
  logic       start;
  logic [9:0] src_addr;
  logic [9:0] dst_addr;
  logic [10:0] len;
  logic       busy, done, dm_en;
  logic [9:0] dm_addr;
  logic [7:0] dm_in;
  logic [7:0] dm_out;
`ifdef DM_COPY_FILL_EN
  logic       fill_s;
  logic [7:0] fill_data_s;
`endif

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];
  logic       init_done = 1'b0;
  logic       pre_we = 1'b0;
  logic [9:0] pre_a = '0;
  logic [7:0] pre_d = '0;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_mis = 0;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int  done_q[$];

  dm_copy_engine dut (
    .CLK      (clk),
    .RST      (rst_n_s),
    .START    (start),
    .SRC_ADDR (src_addr),
    .DST_ADDR (dst_addr),
    .LEN      (len),
    .BUSY     (busy),
    .DONE     (done),
    .DM_EN    (dm_en),
    .DM_ADDR  (dm_addr),
    .DM_IN    (dm_in),
    .DM_OUT   (dm_out)
`ifdef DM_COPY_FILL_EN
    ,
    .FILL     (fill_s),
    .FILL_DATA(fill_data_s)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) ^ (i >> 3));
  endfunction

  // Data memory: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
      init_done <= 1'b1;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (dm_en) begin
      mem[dm_addr] <= dm_in;
    end
  end

  assign dm_out = mem[dm_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every DUT memory access and DONE must match the head of its queue.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
      check("done_busy", busy, 0);
      check("fin_addr", dm_addr, 0);
      check("fin_din", dm_in, 0);
    end
    if (dm_en === 1'b1) begin
      if (wr_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.n);
        check("wr_addr", dm_addr, e.addr);
        check("wr_data", dm_in, e.data);
        check("wr_busy", busy, 1);
      end
    end else if (busy === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected_read", 1, 0);
      else begin
        rd_t r;
        r = rd_q.pop_front();
        check("rd_cycle", cyc, r.n);
        check("rd_addr", dm_addr, r.addr);
        check("rd_din", dm_in, 0);
      end
    end
  end

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one accepted START and predicts up to max_bytes writes; DONE only if the copy can finish.
  task automatic issue(input logic [9:0] src, input logic [9:0] dst, input int ln, input bit fill,
                       input logic [7:0] fd, input int max_bytes, output int k);
    int eff, nb;
    logic [9:0] a_src, a_dst;
    logic [7:0] d;
    @(negedge clk);
    src_addr = src;
    dst_addr = dst;
    len      = 11'(ln);
`ifdef DM_COPY_FILL_EN
    fill_s      = fill;
    fill_data_s = fd;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
    eff = (ln > 1024) ? 1024 : ln;
    nb  = (eff < max_bytes) ? eff : max_bytes;
    for (int i = 0; i < nb; i++) begin
      a_src = src + 10'(i);
      a_dst = dst + 10'(i);
      if (fill) begin
        ref_mem[a_dst] = fd;
        wr_q.push_back('{k + i, a_dst, fd});
      end else begin
        rd_q.push_back('{k + 2 * i, a_src});
        d = ref_mem[a_src];
        ref_mem[a_dst] = d;
        wr_q.push_back('{k + 1 + 2 * i, a_dst, d});
      end
    end
    if (nb == eff) done_q.push_back(fill ? k + eff : k + 2 * eff);
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int c;
    int bad;
    c = 0;
    while ((wr_q.size() + rd_q.size() + done_q.size()) != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check({tag, "_timeout"}, 32'(c >= budget), 0);
    repeat (10) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({tag, "_mem"}, bad, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    rst_n_s  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
`ifdef DM_COPY_FILL_EN
    fill_s      = 1'b0;
    fill_data_s = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_s = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dm_en", dm_en, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_in", dm_in, 0);

    // Basic four-byte copy.
    poke(10'h010, 8'hA1);
    poke(10'h011, 8'hB2);
    poke(10'h012, 8'hC3);
    poke(10'h013, 8'hD4);
    issue(10'h010, 10'h200, 4, 1'b0, 8'h00, 1 << 20, k);
    wait_quiet(50, "copy4");
    check("copy4_byte0", mem[10'h200], 8'hA1);
    check("copy4_byte3", mem[10'h203], 8'hD4);

    // Zero length: DONE the cycle after START, no memory traffic.
    issue(10'h123, 10'h321, 0, 1'b0, 8'h00, 1 << 20, k);
    wait_quiet(20, "len0");

    // Wrap-around with destination one ahead of source: the first byte propagates.
    poke(10'h3FE, 8'h11);
    poke(10'h3FF, 8'h22);
    poke(10'h000, 8'h33);
    issue(10'h3FE, 10'h3FF, 3, 1'b0, 8'h00, 1 << 20, k);
    wait_quiet(50, "wrap");
    check("wrap_001", mem[10'h001], 8'h11);

    // A second START during an operation must be ignored.
    issue(10'h080, 10'h180, 4, 1'b0, 8'h00, 1 << 20, k);
    while (cyc < k + 2) @(negedge clk);
    src_addr = 10'h3A0;
    dst_addr = 10'h0F0;
    len      = 11'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_quiet(50, "ignore_start");

    // Reset sampled at the end of the second-byte read: one byte written, no DONE.
    issue(10'h040, 10'h300, 8, 1'b0, 8'h00, 1, k);
    rd_q.push_back('{k + 2, 10'h041});
    while (cyc < k + 2) @(negedge clk);
    rst_n_s = 1'b0;
    @(posedge clk);
    #1;
    rst_n_s = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_dm_en", dm_en, 0);
    check("abort_dm_addr", dm_addr, 0);
    wait_quiet(30, "abort");

    // Normal copy after the abort, crossing the top of memory.
    issue(10'h3FC, 10'h050, 5, 1'b0, 8'h00, 1 << 20, k);
    wait_quiet(50, "after_abort");

    // Oversized length clamps to 1024 bytes.
    issue(10'h000, 10'h200, 1500, 1'b0, 8'h00, 1 << 20, k);
    wait_quiet(2200, "clamp");

`ifdef DM_COPY_FILL_EN
    issue(10'h3C0, 10'h100, 3, 1'b1, 8'h5A, 1 << 20, k);
    wait_quiet(30, "fill");
    check("fill_102", mem[10'h102], 8'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
